// File: rtl/piano_key_arbiter.sv
// Eight-key piano voice: synchronize and debounce the keys, pick one by last-press
// priority, and play its square wave with half-periods that never change mid-phase.
module piano_key_arbiter #(
  parameter int DEB_CYCLES = 500000,
  parameter int DIV_SHIFT  = 0        // scales the note table down; 0 gives real pitches
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] keys,
  input  logic       enable,
  output logic       tone,
  output logic       active,
  output logic [2:0] note_idx
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;

  function automatic logic [2:0] top_bit(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [16:0] half_of(input logic [2:0] idx);
    logic [16:0] h;
    case (idx)
      3'd0:    h = 17'd95554;
      3'd1:    h = 17'd85132;
      3'd2:    h = 17'd75842;
      3'd3:    h = 17'd71586;
      3'd4:    h = 17'd63775;
      3'd5:    h = 17'd56818;
      3'd6:    h = 17'd50619;
      default: h = 17'd47778;
    endcase
    return h >> DIV_SHIFT;
  endfunction

  logic [7:0]    sync1_reg, sync2_reg, deb_reg, deb_next, flip, rises;
  logic [CW-1:0] deb_cnt_reg [8];

  // A key flips once it has disagreed with its debounced value for DEB_CYCLES cycles
  // and still disagrees on the following edge.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_deb
      assign flip[gi] = (sync2_reg[gi] != deb_reg[gi]) &&
                        (deb_cnt_reg[gi] == CW'(DEB_CYCLES));
      always_ff @(posedge clk) begin
        if (!reset)                           deb_cnt_reg[gi] <= '0;
        else if (sync2_reg[gi] == deb_reg[gi]) deb_cnt_reg[gi] <= '0;
        else if (flip[gi])                    deb_cnt_reg[gi] <= '0;
        else                                  deb_cnt_reg[gi] <= deb_cnt_reg[gi] + CW'(1);
      end
    end
  endgenerate

  assign deb_next = deb_reg ^ flip;
  assign rises    = flip & ~deb_reg;

  logic       sel_valid_reg, sel_valid_next;
  logic [2:0] sel_idx_reg, sel_idx_next;

  always_comb begin
    sel_valid_next = sel_valid_reg;
    sel_idx_next   = sel_idx_reg;
    if (|rises) begin
      sel_valid_next = 1'b1;
      sel_idx_next   = top_bit(rises);
    end else if (sel_valid_reg && !deb_next[sel_idx_reg]) begin
      sel_valid_next = |deb_next;
      sel_idx_next   = top_bit(deb_next);
    end
  end

  state_t      state_reg, state_next;
  logic [16:0] cnt_reg, cnt_next, div_reg, div_next;
  logic        tone_reg, tone_next, active_reg;
  logic [2:0]  note_reg, note_next;
  logic        want, terminal;

  assign want     = sel_valid_reg && enable;
  assign terminal = (cnt_reg == div_reg - 17'd1);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    div_next   = div_reg;
    tone_next  = tone_reg;
    note_next  = note_reg;
    case (state_reg)
      IDLE: begin
        cnt_next  = '0;
        tone_next = 1'b0;
        if (want) begin
          state_next = PLAY;
          tone_next  = 1'b1;
          div_next   = half_of(sel_idx_reg);
          note_next  = sel_idx_reg;
        end
      end
      default: begin
        if (state_reg == DRAIN && !want) begin
          if (terminal) begin
            state_next = IDLE;
            tone_next  = 1'b0;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 17'd1;
          end
        end else begin
          // A different selection only takes over at a phase boundary.
          state_next = want ? PLAY : DRAIN;
          if (terminal) begin
            tone_next = ~tone_reg;
            cnt_next  = '0;
            if (want && sel_idx_reg != note_reg) begin
              div_next  = half_of(sel_idx_reg);
              note_next = sel_idx_reg;
            end
          end else begin
            cnt_next = cnt_reg + 17'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_reg     <= '0;
      sync2_reg     <= '0;
      deb_reg       <= '0;
      sel_valid_reg <= 1'b0;
      sel_idx_reg   <= '0;
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      div_reg       <= '0;
      tone_reg      <= 1'b0;
      note_reg      <= '0;
      active_reg    <= 1'b0;
    end else begin
      sync1_reg     <= keys;
      sync2_reg     <= sync1_reg;
      deb_reg       <= deb_next;
      sel_valid_reg <= sel_valid_next;
      sel_idx_reg   <= sel_idx_next;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      div_reg       <= div_next;
      tone_reg      <= tone_next;
      note_reg      <= note_next;
      active_reg    <= (state_next != IDLE);
    end
  end

  assign tone     = tone_reg;
  assign active   = active_reg;
  assign note_idx = note_reg;
endmodule
